// File: rtl/farbborg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : farbborg_pkg
// Description : Shared types and defaults for the Farbborg PWM write arbiter.
//               Holds the arbiter state encoding and the default widths and
//               clear value used by farbborg_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package farbborg_pkg;

  localparam int         PWM_AW_DEF    = 11;     // PWM word-address width
  localparam int         WB_AW         = 13;     // Wishbone byte-address width
  localparam logic [7:0] CLEAR_VAL_DEF = 8'h00;  // value written by a clear

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK0  = 2'd1,
    ST_ACK1  = 2'd2,
    ST_CLEAR = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/farbborg_wr_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin picker, purely combinational.
//               The "last served" bit is owned by the parent.
// Ports       : req[1:0]    - request vector, bit N = port N
//               last_grant  - port that was granted most recently
//               gnt[1:0]    - grant vector, one-hot or all zero
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import farbborg_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: hand the grant to whichever port was not served last.
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/farbborg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : farbborg_wr_arbiter
// Description : Shares the single write port of the PWM brightness memory
//               between two Wishbone classic slave ports (0 = CPU,
//               1 = animation/DMA). Round-robin, one grant per transaction,
//               one-cycle ack latency. Optional frame-clear sequencer writes
//               CLEAR_VAL to every word.
// Config      : FARBBORG_CLEAR_EN - when defined, builds the clear sequencer
//               (CLEAR state, counter, pending flag). When undefined,
//               clear_start is ignored and clear_busy is tied low.
// Ports       : clk, reset_n         - clock, async active-low reset
//               wbN_adr_i/dat_i      - Wishbone byte address / write data
//               wbN_cyc_i/stb_i/we_i - Wishbone classic controls
//               wbN_dat_o            - read data, always zero (write-only mem)
//               wbN_ack_o            - acknowledge
//               clear_start          - one-cycle clear request pulse
//               clear_busy           - clear pending or running
//               pwm_addr/din/we      - registered write port to the PWM memory
// Revision    : 1.0 - initial release
// ============================================================================
module farbborg_wr_arbiter
  import farbborg_pkg::*;
#(
  parameter int unsigned PWM_AW      = PWM_AW_DEF,
  parameter int unsigned CLEAR_DEPTH = 2048,
  parameter logic [7:0]  CLEAR_VAL   = CLEAR_VAL_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WB_AW-1:0]  wb0_adr_i,
  input  logic [7:0]        wb0_dat_i,
  output logic [7:0]        wb0_dat_o,
  input  logic              wb0_cyc_i,
  input  logic              wb0_stb_i,
  input  logic              wb0_we_i,
  output logic              wb0_ack_o,
  input  logic [WB_AW-1:0]  wb1_adr_i,
  input  logic [7:0]        wb1_dat_i,
  output logic [7:0]        wb1_dat_o,
  input  logic              wb1_cyc_i,
  input  logic              wb1_stb_i,
  input  logic              wb1_we_i,
  output logic              wb1_ack_o,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [PWM_AW-1:0] pwm_addr,
  output logic [7:0]        pwm_din,
  output logic              pwm_we
);

  arb_state_t       state;
  logic             last_grant;
  logic             ack0_r;
  logic             ack1_r;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [WB_AW-1:0] sel_adr;
  logic [7:0]       sel_dat;
  logic             sel_we;
  logic             unused_ok;

  assign req = {wb1_cyc_i & wb1_stb_i, wb0_cyc_i & wb0_stb_i};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Fields of the winning port; only meaningful when gnt is non-zero.
  assign sel_adr = gnt[1] ? wb1_adr_i : wb0_adr_i;
  assign sel_dat = gnt[1] ? wb1_dat_i : wb0_dat_i;
  assign sel_we  = gnt[1] ? wb1_we_i  : wb0_we_i;

  // A master that drops stb during its ack cycle sees no ack, but the write
  // already presented to the memory still happens.
  assign wb0_ack_o = ack0_r & wb0_stb_i;
  assign wb1_ack_o = ack1_r & wb1_stb_i;
  assign wb0_dat_o = 8'h00;
  assign wb1_dat_o = 8'h00;

`ifdef FARBBORG_CLEAR_EN
  // One extra bit so the terminal value CLEAR_DEPTH is representable and the
  // counter never wraps inside a sequence.
  localparam logic [PWM_AW:0] CLR_END = (PWM_AW+1)'(CLEAR_DEPTH);

  logic              clear_pend;
  logic [PWM_AW:0]   clr_cnt;   // address of the *next* clear write

  assign clear_busy = (state == ST_CLEAR) | clear_pend;
  assign unused_ok  = &{1'b0, sel_adr[1:0]};
`else
  assign clear_busy = 1'b0;
  assign unused_ok  = &{1'b0, sel_adr[1:0], clear_start, CLEAR_VAL, CLEAR_DEPTH};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      pwm_we     <= 1'b0;
      pwm_addr   <= '0;
      pwm_din    <= '0;
`ifdef FARBBORG_CLEAR_EN
      clear_pend <= 1'b0;
      clr_cnt    <= '0;
`endif
    end else begin
`ifdef FARBBORG_CLEAR_EN
      // Pulses during a running clear are dropped; elsewhere they are held.
      if (clear_start && (state != ST_CLEAR)) begin
        clear_pend <= 1'b1;
      end
`endif
      case (state)
        ST_IDLE: begin
          pwm_we <= 1'b0;
`ifdef FARBBORG_CLEAR_EN
          if (clear_pend) begin
            // Address 0 is issued on the entry edge, so the counter starts at 1.
            state      <= ST_CLEAR;
            clear_pend <= 1'b0;
            clr_cnt    <= (PWM_AW+1)'(1);
            pwm_we     <= 1'b1;
            pwm_addr   <= '0;
            pwm_din    <= CLEAR_VAL;
          end else if (|gnt) begin
`else
          if (|gnt) begin
`endif
            state      <= gnt[1] ? ST_ACK1 : ST_ACK0;
            ack0_r     <= gnt[0];
            ack1_r     <= gnt[1];
            last_grant <= gnt[1];
            pwm_addr   <= sel_adr[PWM_AW+1:2];
            pwm_din    <= sel_dat;
            pwm_we     <= sel_we;
          end
        end

        ST_ACK0, ST_ACK1: begin
          state  <= ST_IDLE;
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          pwm_we <= 1'b0;
        end

`ifdef FARBBORG_CLEAR_EN
        ST_CLEAR: begin
          if (clr_cnt == CLR_END) begin
            state  <= ST_IDLE;
            pwm_we <= 1'b0;
          end else begin
            pwm_addr <= clr_cnt[PWM_AW-1:0];
            clr_cnt  <= clr_cnt + (PWM_AW+1)'(1);
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_farbborg_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_farbborg_wr_arbiter
// Description : Self-checking bench for farbborg_wr_arbiter. Masters are
//               transaction queues; a transaction-level model (one transfer
//               then one dead cycle, round-robin on contention) predicts every
//               cycle's ack and PWM write. FARBBORG_CLEAR_EN selects the clear
//               scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_farbborg_wr_arbiter;

  localparam int         AW    = 11;
  localparam int         DEPTH = 2048;
  localparam logic [7:0] CVAL  = 8'h00;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [12:0]   wb0_adr_i, wb1_adr_i;
  logic [7:0]    wb0_dat_i, wb1_dat_i, wb0_dat_o, wb1_dat_o;
  logic          wb0_cyc_i, wb0_stb_i, wb0_we_i, wb0_ack_o;
  logic          wb1_cyc_i, wb1_stb_i, wb1_we_i, wb1_ack_o;
  logic          clear_start, clear_busy;
  logic [AW-1:0] pwm_addr;
  logic [7:0]    pwm_din;
  logic          pwm_we;

  farbborg_wr_arbiter #(
    .PWM_AW      (AW),
    .CLEAR_DEPTH (DEPTH),
    .CLEAR_VAL   (CVAL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wb0_adr_i   (wb0_adr_i),
    .wb0_dat_i   (wb0_dat_i),
    .wb0_dat_o   (wb0_dat_o),
    .wb0_cyc_i   (wb0_cyc_i),
    .wb0_stb_i   (wb0_stb_i),
    .wb0_we_i    (wb0_we_i),
    .wb0_ack_o   (wb0_ack_o),
    .wb1_adr_i   (wb1_adr_i),
    .wb1_dat_i   (wb1_dat_i),
    .wb1_dat_o   (wb1_dat_o),
    .wb1_cyc_i   (wb1_cyc_i),
    .wb1_stb_i   (wb1_stb_i),
    .wb1_we_i    (wb1_we_i),
    .wb1_ack_o   (wb1_ack_o),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .pwm_addr    (pwm_addr),
    .pwm_din     (pwm_din),
    .pwm_we      (pwm_we)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [12:0] adr;
    logic [7:0]  dat;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   last_port;   // port the model believes was served last
  bit   dead;        // model: previous cycle carried a transfer

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t rnd_txn(input bit force_we);
    txn_t t;
    t.we  = force_we ? 1'b1 : ($urandom_range(0, 3) != 0);
    t.adr = 13'($urandom);
    t.dat = 8'($urandom);
    return t;
  endfunction

  // Present the head of each queue; idle ports carry random junk on adr/dat.
  task automatic drive_heads();
    wb0_cyc_i = (q0.size() != 0);
    wb0_stb_i = wb0_cyc_i;
    if (q0.size() != 0) begin
      wb0_we_i = q0[0].we; wb0_adr_i = q0[0].adr; wb0_dat_i = q0[0].dat;
    end else begin
      wb0_we_i = 1'($urandom); wb0_adr_i = 13'($urandom); wb0_dat_i = 8'($urandom);
    end
    wb1_cyc_i = (q1.size() != 0);
    wb1_stb_i = wb1_cyc_i;
    if (q1.size() != 0) begin
      wb1_we_i = q1[0].we; wb1_adr_i = q1[0].adr; wb1_dat_i = q1[0].dat;
    end else begin
      wb1_we_i = 1'($urandom); wb1_adr_i = 13'($urandom); wb1_dat_i = 8'($urandom);
    end
  endtask

  // One clock of the transaction model: a pending request is served unless
  // the previous cycle was a transfer; contention goes to the other port.
  task automatic cycle(input string tag);
    int   exp_port;
    txn_t t;
    drive_heads();
    @(posedge clk); #2;
    exp_port = -1;
    if (!dead) begin
      if (q0.size() != 0 && q1.size() != 0) exp_port = (last_port == 0) ? 1 : 0;
      else if (q0.size() != 0)              exp_port = 0;
      else if (q1.size() != 0)              exp_port = 1;
    end
    chk({tag, " dat_o"}, {wb0_dat_o, wb1_dat_o}, 0);
    chk({tag, " busy"}, clear_busy, 0);
    if (exp_port < 0) begin
      chk({tag, " idle ack"}, {wb1_ack_o, wb0_ack_o}, 2'b00);
      chk({tag, " idle we"}, pwm_we, 0);
      dead = 0;
    end else begin
      t = (exp_port == 0) ? q0[0] : q1[0];
      chk({tag, " ack"}, {wb1_ack_o, wb0_ack_o}, (exp_port == 0) ? 2'b01 : 2'b10);
      chk({tag, " addr"}, pwm_addr, t.adr[12:2]);
      chk({tag, " din"}, pwm_din, t.dat);
      chk({tag, " we"}, pwm_we, t.we);
      if (exp_port == 0) void'(q0.pop_front());
      else               void'(q1.pop_front());
      last_port = exp_port;
      dead      = 1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      cycle(tag);
      n++;
    end
    cycle({tag, " settle"});
    cycle({tag, " settle"});
  endtask

  // Asynchronous reset applied away from the clock edge.
  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, " we"}, pwm_we, 0);
    chk({tag, " busy"}, clear_busy, 0);
    chk({tag, " ack"}, {wb1_ack_o, wb0_ack_o}, 2'b00);
    chk({tag, " addr/din"}, {pwm_addr, pwm_din}, 0);
    q0.delete();
    q1.delete();
    drive_heads();
    last_port = 1;
    dead      = 0;
    @(posedge clk); #5;
    reset_n = 1'b1;
  endtask

  initial begin
    txn_t t;
    reset_n     = 1'b0;
    clear_start = 1'b0;
    last_port   = 1;
    dead        = 0;
    drive_heads();
    repeat (2) @(posedge clk);
    #2;
    chk("rst we", pwm_we, 0);
    chk("rst addr", pwm_addr, 0);
    chk("rst din", pwm_din, 0);
    chk("rst ack", {wb1_ack_o, wb0_ack_o}, 2'b00);
    chk("rst busy", clear_busy, 0);
    chk("rst dat_o", {wb0_dat_o, wb1_dat_o}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle("idle");

    // Single write from port 0
    q0.push_back(txn_t'{1'b1, 13'h0014, 8'hA5});
    cycle("wr1");
    chk("wr1 addr 005", pwm_addr, 11'h005);
    chk("wr1 din A5", pwm_din, 8'hA5);
    cycle("wr1 post");
    cycle("wr1 post");

    // Read from port 1
    q1.push_back(txn_t'{1'b0, 13'h0100, 8'($urandom)});
    cycle("rd1");
    chk("rd1 dat_o", wb1_dat_o, 8'h00);
    cycle("rd1 post");
    cycle("rd1 post");

    // Master drops stb during the ack cycle
    t = rnd_txn(1'b1);
    q0.push_back(t);
    drive_heads();
    @(posedge clk); #2;
    chk("drop ack before", wb0_ack_o, 1);
    wb0_stb_i = 1'b0;
    wb0_cyc_i = 1'b0;
    #1;
    chk("drop ack masked", wb0_ack_o, 0);
    chk("drop we", pwm_we, 1);
    chk("drop addr", pwm_addr, t.adr[12:2]);
    chk("drop din", pwm_din, t.dat);
    void'(q0.pop_front());
    last_port = 0;
    dead      = 1;
    q1.push_back(rnd_txn(1'b1));
    drain("drop next");

`ifdef FARBBORG_CLEAR_EN
    // Clear while port 0 holds a write; second pulse mid-clear is ignored
    begin
      int nwr = 0;
      clear_start = 1'b1;
      drive_heads();
      @(posedge clk); #2;
      clear_start = 1'b0;
      chk("clr pend busy", clear_busy, 1);
      chk("clr pend we", pwm_we, 0);
      t = rnd_txn(1'b1);
      q0.push_back(t);
      drive_heads();
      for (int k = 0; k < DEPTH; k++) begin
        clear_start = (k == 1000);
        @(posedge clk); #2;
        chk("clr write", {pwm_we, pwm_addr, pwm_din, wb0_ack_o, clear_busy},
            {1'b1, 11'(k), CVAL, 1'b0, 1'b1});
        if (pwm_we) nwr++;
      end
      clear_start = 1'b0;
      chk("clr count", nwr, DEPTH);
      @(posedge clk); #2;
      chk("clr end", {pwm_we, wb0_ack_o, clear_busy}, 3'b000);
      @(posedge clk); #2;
      chk("clr held ack", {wb1_ack_o, wb0_ack_o}, 2'b01);
      chk("clr held write", {pwm_we, pwm_addr, pwm_din}, {1'b1, t.adr[12:2], t.dat});
      void'(q0.pop_front());
      last_port = 0;
      dead      = 1;
      repeat (4) cycle("clr no repeat");
    end

    // Reset in the middle of a clear
    clear_start = 1'b1;
    drive_heads();
    @(posedge clk); #2;
    clear_start = 1'b0;
    for (int k = 0; k <= 300; k++) begin
      @(posedge clk); #2;
    end
    chk("rclr at 300", {pwm_we, pwm_addr}, {1'b1, 11'd300});
    apply_reset("rclr rst");
    repeat (6) cycle("rclr after");
`else
    // Without the sequencer a clear pulse does nothing to Wishbone traffic
    clear_start = 1'b1;
    q0.push_back(rnd_txn(1'b1));
    cycle("noclr");
    clear_start = 1'b0;
    drain("noclr");
`endif

    // Reset during an ack cycle
    q1.push_back(rnd_txn(1'b1));
    drive_heads();
    @(posedge clk); #2;
    chk("rtx ack", wb1_ack_o, 1);
    apply_reset("rtx rst");
    cycle("rtx after");
    cycle("rtx after");

    // Contention: 4 writes each, right after reset (port 0 first)
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rnd_txn(1'b1));
      q1.push_back(rnd_txn(1'b1));
    end
    drain("cont4");

    // Randomized contention rounds with uneven queues and reads
    for (int r = 0; r < 6; r++) begin
      int n0 = $urandom_range(0, 6);
      int n1 = $urandom_range(1, 6);
      for (int i = 0; i < n0; i++) q0.push_back(rnd_txn(1'b0));
      for (int i = 0; i < n1; i++) q1.push_back(rnd_txn(1'b0));
      drain("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
